// File: rtl/core_pkg.sv
// Shared definitions for the core controller: FSM state encoding, instruction-word
// bit positions and the idle-word builder.
package core_pkg;

    localparam int ADDR_W = 11;
    localparam int CNT_W  = 12;
    localparam int INST_W = 34;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_XLOAD  = 4'd1,
        S_WL0    = 4'd2,
        S_KLOAD  = 4'd3,
        S_KDRAIN = 4'd4,
        S_AL0    = 4'd5,
        S_EXEC   = 4'd6,
        S_OUT    = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    localparam int INST_ACC    = 33;
    localparam int INST_P_CEN  = 32;
    localparam int INST_P_WEN  = 31;
    localparam int INST_P_ADDR = 20;
    localparam int INST_X_CEN  = 19;
    localparam int INST_X_WEN  = 18;
    localparam int INST_X_ADDR = 7;
    localparam int INST_OF_RD  = 6;
    localparam int INST_L0_RD  = 3;
    localparam int INST_L0_WR  = 2;
    localparam int INST_EXEC   = 1;
    localparam int INST_KLOAD  = 0;

    // Memories deselected, no strobes; only the accumulate flag may be set.
    function automatic logic [INST_W-1:0] idle_word(input logic acc);
        logic [INST_W-1:0] w;
        w              = 34'd0;
        w[INST_ACC]    = acc;
        w[INST_P_CEN]  = 1'b1;
        w[INST_P_WEN]  = 1'b1;
        w[INST_X_CEN]  = 1'b1;
        w[INST_X_WEN]  = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_addr_cnt.sv
// Loadable 11-bit wrapping address pointer with a companion transfer count and
// compares of that count against a job-dependent limit.
module ctrl_addr_cnt
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic              inc,
    input  logic [CNT_W-1:0]  limit,
    output logic [ADDR_W-1:0] addr,
    output logic              cnt_done,
    output logic              cnt_last
);

    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  count_r;

    // Pointer and count: load restarts at base, inc advances both (address wraps mod 2048).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r  <= 11'd0;
            count_r <= 12'd0;
        end else if (load) begin
            addr_r  <= base;
            count_r <= 12'd0;
        end else if (inc) begin
            addr_r  <= addr_r + 11'd1;
            count_r <= count_r + 12'd1;
        end else begin
            addr_r  <= addr_r;
            count_r <= count_r;
        end
    end

    assign addr     = addr_r;
    assign cnt_done = (count_r == limit);
    assign cnt_last = ((count_r + 12'd1) == limit);

endmodule

// File: rtl/core_ctrl.sv
// Job sequencer for the systolic core: loads xmem from the host stream, feeds L0,
// loads kernels, executes and drains the output FIFO into pmem.
module core_ctrl
    import core_pkg::*;
#(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int bw      = 4,
    parameter int psum_bw = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [10:0]       num_act,
    input  logic              acc_en,
    input  logic [10:0]       w_base,
    input  logic [10:0]       a_base,
    input  logic [10:0]       p_base,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [bw*row-1:0] in_data,
    input  logic              ofifo_valid,
    output logic [33:0]       inst,
    output logic [bw*row-1:0] d_xmem,
    output logic              busy,
    output logic              done
);

    if (psum_bw < 2 * bw) begin : g_psum_chk
        $error("core_ctrl: psum_bw narrower than a full product");
    end

    localparam logic [CNT_W-1:0] ROW_C = CNT_W'(row);
    localparam logic [CNT_W-1:0] COL_C = CNT_W'(col);

    state_t            state_r, state_nxt_s;
    logic [10:0]       num_act_r;
    logic              acc_en_r;
    logic [10:0]       w_base_r, a_base_r, p_base_r;
    logic              xphase_r, xphase_nxt_s;
    logic [CNT_W-1:0]  cyc_r, cyc_nxt_s;
    logic              l0_pend_r, l0_pend_nxt_s;
    logic              pm_pend_r, pm_pend_nxt_s;
    logic [CNT_W-1:0]  na_s;
    logic              busy_s;

    logic              x_load_s, x_inc_s, x_done_s, x_last_s;
    logic [10:0]       x_base_s, x_addr_s;
    logic [CNT_W-1:0]  x_limit_s;
    logic              p_load_s, p_inc_s, p_done_s, p_last_s;
    logic [10:0]       p_addr_s;

    logic xm_cen_s, xm_wen_s, pm_cen_s, pm_wen_s;
    logic ofifo_rd_s, l0_rd_s, l0_wr_s, exec_s, kload_s;
    logic [INST_W-1:0] inst_s;

    assign na_s   = {1'b0, num_act_r};
    assign busy_s = (state_r != S_IDLE);

    ctrl_addr_cnt u_xcnt (
        .clk      (clk),
        .reset    (reset),
        .load     (x_load_s),
        .base     (x_base_s),
        .inc      (x_inc_s),
        .limit    (x_limit_s),
        .addr     (x_addr_s),
        .cnt_done (x_done_s),
        .cnt_last (x_last_s)
    );

    ctrl_addr_cnt u_pcnt (
        .clk      (clk),
        .reset    (reset),
        .load     (p_load_s),
        .base     (p_base_r),
        .inc      (p_inc_s),
        .limit    (na_s),
        .addr     (p_addr_s),
        .cnt_done (p_done_s),
        .cnt_last (p_last_s)
    );

    // FSM state, phase/cycle counters and the one-cycle-delayed L0/pmem strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            xphase_r  <= 1'b0;
            cyc_r     <= 12'd0;
            l0_pend_r <= 1'b0;
            pm_pend_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            xphase_r  <= xphase_nxt_s;
            cyc_r     <= cyc_nxt_s;
            l0_pend_r <= l0_pend_nxt_s;
            pm_pend_r <= pm_pend_nxt_s;
        end
    end

    // Job parameters are captured only when a start is accepted from IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_act_r <= 11'd0;
            acc_en_r  <= 1'b0;
            w_base_r  <= 11'd0;
            a_base_r  <= 11'd0;
            p_base_r  <= 11'd0;
        end else if ((state_r == S_IDLE) && start) begin
            num_act_r <= num_act;
            acc_en_r  <= acc_en;
            w_base_r  <= w_base;
            a_base_r  <= a_base;
            p_base_r  <= p_base;
        end else begin
            num_act_r <= num_act_r;
            acc_en_r  <= acc_en_r;
            w_base_r  <= w_base_r;
            a_base_r  <= a_base_r;
            p_base_r  <= p_base_r;
        end
    end

    // Next-state, pointer control and per-cycle strobes.
    always_comb begin
        state_nxt_s   = state_r;
        xphase_nxt_s  = xphase_r;
        cyc_nxt_s     = cyc_r;
        l0_pend_nxt_s = 1'b0;
        pm_pend_nxt_s = 1'b0;
        x_load_s      = 1'b0;
        x_base_s      = w_base_r;
        x_inc_s       = 1'b0;
        x_limit_s     = ROW_C;
        p_load_s      = 1'b0;
        p_inc_s       = 1'b0;
        xm_cen_s      = 1'b1;
        xm_wen_s      = 1'b1;
        pm_cen_s      = 1'b1;
        pm_wen_s      = 1'b1;
        ofifo_rd_s    = 1'b0;
        l0_rd_s       = 1'b0;
        l0_wr_s       = 1'b0;
        exec_s        = 1'b0;
        kload_s       = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s  = S_XLOAD;
                    x_load_s     = 1'b1;
                    x_base_s     = w_base;
                    xphase_nxt_s = 1'b0;
                end else begin
                    state_nxt_s  = S_IDLE;
                end
            end
            S_XLOAD: begin
                // Weights fill first (row beats), then the pointer is rebased for activations.
                x_limit_s = xphase_r ? na_s : ROW_C;
                if (in_valid) begin
                    xm_cen_s = 1'b0;
                    xm_wen_s = 1'b0;
                    if (x_last_s && (xphase_r || (num_act_r == 11'd0))) begin
                        state_nxt_s  = S_WL0;
                        x_load_s     = 1'b1;
                        x_base_s     = w_base_r;
                        xphase_nxt_s = 1'b0;
                    end else if (x_last_s) begin
                        x_load_s     = 1'b1;
                        x_base_s     = a_base_r;
                        xphase_nxt_s = 1'b1;
                    end else begin
                        x_inc_s      = 1'b1;
                    end
                end else begin
                    x_inc_s = 1'b0;
                end
            end
            S_WL0, S_AL0: begin
                // SRAM data arrives a cycle after the read, so L0 writes trail by one.
                x_limit_s = (state_r == S_WL0) ? ROW_C : na_s;
                l0_wr_s   = l0_pend_r;
                if (!x_done_s) begin
                    xm_cen_s      = 1'b0;
                    x_inc_s       = 1'b1;
                    l0_pend_nxt_s = 1'b1;
                end else begin
                    state_nxt_s   = (state_r == S_WL0) ? S_KLOAD : S_EXEC;
                    cyc_nxt_s     = 12'd0;
                end
            end
            S_KLOAD: begin
                kload_s = 1'b1;
                l0_rd_s = 1'b1;
                if (cyc_r == (ROW_C - 12'd1)) begin
                    state_nxt_s = S_KDRAIN;
                    cyc_nxt_s   = 12'd0;
                end else begin
                    cyc_nxt_s   = cyc_r + 12'd1;
                end
            end
            S_KDRAIN: begin
                if (cyc_r == (COL_C - 12'd1)) begin
                    cyc_nxt_s = 12'd0;
                    if (num_act_r == 11'd0) begin
                        state_nxt_s = S_DONE;
                    end else begin
                        state_nxt_s = S_AL0;
                        x_load_s    = 1'b1;
                        x_base_s    = a_base_r;
                    end
                end else begin
                    cyc_nxt_s = cyc_r + 12'd1;
                end
            end
            S_EXEC: begin
                exec_s  = 1'b1;
                l0_rd_s = 1'b1;
                if (cyc_r == (na_s - 12'd1)) begin
                    state_nxt_s = S_OUT;
                    p_load_s    = 1'b1;
                    cyc_nxt_s   = 12'd0;
                end else begin
                    cyc_nxt_s   = cyc_r + 12'd1;
                end
            end
            S_OUT: begin
                if (ofifo_valid && (cyc_r < na_s)) begin
                    ofifo_rd_s    = 1'b1;
                    cyc_nxt_s     = cyc_r + 12'd1;
                    pm_pend_nxt_s = 1'b1;
                end else begin
                    ofifo_rd_s    = 1'b0;
                end
                if (pm_pend_r && !p_done_s) begin
                    pm_cen_s    = 1'b0;
                    pm_wen_s    = 1'b0;
                    p_inc_s     = 1'b1;
                    state_nxt_s = p_last_s ? S_DONE : S_OUT;
                end else begin
                    p_inc_s     = 1'b0;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Instruction word assembly; addresses are zero whenever the memory is deselected.
    always_comb begin
        inst_s              = idle_word(busy_s ? acc_en_r : 1'b0);
        inst_s[INST_P_CEN]  = pm_cen_s;
        inst_s[INST_P_WEN]  = pm_wen_s;
        inst_s[INST_X_CEN]  = xm_cen_s;
        inst_s[INST_X_WEN]  = xm_wen_s;
        inst_s[INST_OF_RD]  = ofifo_rd_s;
        inst_s[INST_L0_RD]  = l0_rd_s;
        inst_s[INST_L0_WR]  = l0_wr_s;
        inst_s[INST_EXEC]   = exec_s;
        inst_s[INST_KLOAD]  = kload_s;
        if (!pm_cen_s) begin
            inst_s[INST_P_ADDR +: ADDR_W] = p_addr_s;
        end else begin
            inst_s[INST_P_ADDR +: ADDR_W] = 11'd0;
        end
        if (!xm_cen_s) begin
            inst_s[INST_X_ADDR +: ADDR_W] = x_addr_s;
        end else begin
            inst_s[INST_X_ADDR +: ADDR_W] = 11'd0;
        end
    end

    assign inst     = inst_s;
    assign d_xmem   = in_data;
    assign in_ready = (state_r == S_XLOAD);
    assign busy     = busy_s;
    assign done     = (state_r == S_DONE);

endmodule

// File: tb/tb_core_ctrl.sv
// Randomized scoreboard bench for core_ctrl: expected memory traffic is queued at job
// issue and a negedge monitor pops and compares as the instruction word shows it.
module tb_core_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int BW  = 4;
    localparam int DW  = BW * ROW;
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [10:0]   num_act, w_base, a_base, p_base;
    logic          acc_en;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          ofifo_valid;
    logic [33:0]   inst;
    logic [DW-1:0] d_xmem;
    logic          busy, done;

    core_ctrl #(.row(ROW), .col(COL), .bw(BW), .psum_bw(16)) dut (
        .clk(clk), .reset(reset), .start(start), .num_act(num_act), .acc_en(acc_en),
        .w_base(w_base), .a_base(a_base), .p_base(p_base),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ofifo_valid(ofifo_valid), .inst(inst), .d_xmem(d_xmem), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [10:0] addr; logic [DW-1:0] data; } xw_t;
    typedef struct { int na; logic acc; } job_t;

    xw_t         xw_q[$];
    logic [10:0] xr_q[$];
    logic [10:0] pw_q[$];
    job_t        job_q[$];

    int total = 0;
    int bad   = 0;
    int ocnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int n_l0, n_k, n_e, n_o, n_p, n_rd, cyc, last_k;
    logic prev_xrd, prev_ord, prev_done;

    always @(negedge clk) begin : monitor
        xw_t  e;
        job_t j;
        logic [10:0] a;
        if (!reset) begin
            xw_q.delete(); xr_q.delete(); pw_q.delete(); job_q.delete();
            n_l0 = 0; n_k = 0; n_e = 0; n_o = 0; n_p = 0; n_rd = 0; last_k = 0;
            prev_xrd = 1'b0; prev_ord = 1'b0; prev_done = 1'b0;
        end else begin
            check("d_xmem", d_xmem, in_data);
            check("rsvd_bits", inst[5:4], 2'b00);
            if (prev_done) begin
                check("busy_after_done", busy, 1'b0);
                check("done_width", done, 1'b0);
            end
            if (!busy) begin
                check("idle_word", inst, IDLE_W);
                check("idle_ready", in_ready, 1'b0);
            end else if (job_q.size() > 0) begin
                check("acc_bit", inst[33], job_q[0].acc);
            end
            if (!inst[19] && !inst[18]) begin
                if (xw_q.size() == 0) check("xw_extra", xw_q.size(), 1);
                else begin
                    e = xw_q.pop_front();
                    check("xw_addr", inst[17:7], e.addr);
                    check("xw_data", d_xmem, e.data);
                    check("xw_handshake", in_valid & in_ready, 1'b1);
                end
            end
            if (!inst[19] && inst[18]) begin
                if (xr_q.size() == 0) check("xr_extra", xr_q.size(), 1);
                else begin
                    a = xr_q.pop_front();
                    check("xr_addr", inst[17:7], a);
                end
                if (n_rd == ROW) check("kdrain_gap", cyc - last_k, COL + 1);
                n_rd++;
            end
            if (inst[2]) begin
                check("l0wr_after_read", prev_xrd, 1'b1);
                n_l0++;
            end
            if (inst[0]) begin
                check("kload_l0rd", inst[3], 1'b1);
                n_k++;
                last_k = cyc;
            end
            if (inst[1]) begin
                check("exec_l0rd", inst[3], 1'b1);
                n_e++;
            end
            if (inst[6]) begin
                check("ofifo_rd_valid", ofifo_valid, 1'b1);
                n_o++;
            end
            if (!inst[32] && !inst[31]) begin
                check("pw_after_rd", prev_ord, 1'b1);
                if (pw_q.size() == 0) check("pw_extra", pw_q.size(), 1);
                else begin
                    a = pw_q.pop_front();
                    check("pw_addr", inst[30:20], a);
                end
                n_p++;
            end
            if (done) begin
                check("done_busy", busy, 1'b1);
                if (job_q.size() == 0) check("done_unexpected", job_q.size(), 1);
                else begin
                    j = job_q.pop_front();
                    check("n_l0wr", n_l0, ROW + j.na);
                    check("n_kload", n_k, ROW);
                    check("n_exec", n_e, j.na);
                    check("n_ofifo_rd", n_o, j.na);
                    check("n_pmem_wr", n_p, j.na);
                    check("xw_left", xw_q.size(), 0);
                    check("xr_left", xr_q.size(), 0);
                    check("pw_left", pw_q.size(), 0);
                end
                n_l0 = 0; n_k = 0; n_e = 0; n_o = 0; n_p = 0; n_rd = 0;
            end
            prev_done = done;
            prev_xrd  = !inst[19] && inst[18];
            prev_ord  = inst[6];
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic drive_bg(input int omode);
        logic [5:0] pat;
        pat = 6'b111001;   // 1,0,0,1,1,1 read from bit 0 upward
        case (omode)
            1:       ofifo_valid = 1'b1;
            2:       ofifo_valid = pat[ocnt % 6];
            default: ofifo_valid = 1'($urandom_range(0, 1));
        endcase
        ocnt++;
        start = ($urandom_range(0, 7) == 0);
        if (start) begin
            num_act = 11'($urandom_range(0, 2047));
            w_base  = 11'($urandom_range(0, 2047));
            a_base  = 11'($urandom_range(0, 2047));
            p_base  = 11'($urandom_range(0, 2047));
            acc_en  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic issue(input int na, input int wb, input int ab, input int pb,
                         input logic acc, input int vmode, input int omode);
        logic [DW-1:0] beats[$];
        xw_t  e;
        job_t j;
        int   k, g;
        for (int i = 0; i < ROW + na; i++) begin
            beats.push_back(DW'($urandom));
            e.addr = (i < ROW) ? 11'((wb + i) % 2048) : 11'((ab + i - ROW) % 2048);
            e.data = beats[i];
            xw_q.push_back(e);
        end
        for (int i = 0; i < ROW; i++) xr_q.push_back(11'((wb + i) % 2048));
        for (int i = 0; i < na; i++)  xr_q.push_back(11'((ab + i) % 2048));
        for (int i = 0; i < na; i++)  pw_q.push_back(11'((pb + i) % 2048));
        j.na = na; j.acc = acc;
        job_q.push_back(j);

        @(posedge clk); #1;
        start = 1'b1; num_act = 11'(na); acc_en = acc;
        w_base = 11'(wb); a_base = 11'(ab); p_base = 11'(pb);
        in_valid = 1'b0;
        k = 0; g = 0;
        while (k < ROW + na && g < 4000) begin
            @(posedge clk); #1;
            drive_bg(omode);
            in_valid = (vmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            in_data  = in_valid ? beats[k] : DW'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) k++;
            g++;
        end
        if (k != ROW + na) check("beat_timeout", k, ROW + na);
    endtask

    task automatic wait_done(input int omode);
        logic seen;
        seen = 1'b0;
        for (int g = 0; g < 3000 && !seen; g++) begin
            @(posedge clk); #1;
            drive_bg(omode);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = DW'($urandom);
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", seen, 1'b1);
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inst"}, inst, IDLE_W);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ready"}, in_ready, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        logic seen;
        reset = 1'b0; start = 1'b0; num_act = 11'd0; acc_en = 1'b0;
        w_base = 11'd0; a_base = 11'd0; p_base = 11'd0;
        in_valid = 1'b0; in_data = '0; ofifo_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        @(posedge clk); #2 reset = 1'b1;

        issue(4, 0, 16, 100, 1'b0, 1, 1);          wait_done(1);
        issue(4, 40, 60, 200, 1'b1, 0, 2);         wait_done(2);
        issue(0, 300, 400, 500, 1'b0, 1, 0);       wait_done(0);
        issue(4, 2040, 2046, 2046, 1'b1, 0, 1);    wait_done(1);

        // Abort a job during execute, then run a fresh one.
        issue(3, 10, 20, 30, 1'b1, 1, 0);
        seen = 1'b0;
        for (int g = 0; g < 500 && !seen; g++) begin
            @(posedge clk); #1;
            start = 1'b0; in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (inst[1]) seen = 1'b1;
        end
        if (!seen) check("exec_timeout", seen, 1'b1);
        #1 reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        @(posedge clk); #2 reset = 1'b1;
        issue(5, 100, 120, 140, 1'b0, 0, 0);       wait_done(0);

        for (int r = 0; r < 6; r++) begin
            issue($urandom_range(0, 9), $urandom_range(0, 2047), $urandom_range(0, 2047),
                  $urandom_range(0, 2047), 1'($urandom_range(0, 1)), 0, 0);
            wait_done(0);
        end

        repeat (3) @(posedge clk);
        check("jobs_left", job_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 SHALL have parameters: row, default 8, PE rows / L0 lanes; col, default 8, PE columns; bw, default 4, activation/weight bits; psum_bw, default 16, partial-sum bits.
REQ-002 SHALL have ports: clk  in  1  single clock; reset  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  in  1  one-cycle job start; num_act  in  11  activation vectors per job; acc_en  in  1  accumulate-mode flag for the job.
REQ-004 SHALL have ports: w_base, a_base, p_base  in  11 each  xmem weight, xmem activation and pmem output base addresses.
REQ-005 SHALL have ports: in_valid  in  1; in_ready  out  1; in_data  in  bw*row  host load stream.
REQ-006 SHALL have ports: ofifo_valid  in  1  core output-FIFO has data.
REQ-007 SHALL have ports: inst  out  34  core instruction word; d_xmem  out  bw*row  xmem write data; busy  out  1; done  out  1  one-cycle job-complete pulse.

Function
REQ-008 SHALL drive inst fields: [33] accumulate, [32] pmem CEN, [31] pmem WEN, [30:20] pmem addr, [19] xmem CEN, [18] xmem WEN, [17:7] xmem addr, [6] ofifo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] kernel load; bits [5:4] always 0; CEN/WEN active-low.
REQ-009 SHALL use idle word: both CEN=1, both WEN=1, all other bits 0 except [33]=latched acc_en while busy.
REQ-010 SHALL implement FSM IDLE, XLOAD, WL0, KLOAD, KDRAIN, AL0, EXEC, OUT, DONE.
REQ-011 IDLE: start=1 latches num_act, acc_en, bases -> XLOAD; start while not IDLE SHALL be ignored.
REQ-012 XLOAD: in_ready=1; each in_valid&in_ready beat SHALL write in_data to xmem (CEN=0, WEN=0) at w_base+k for beats k<row, then a_base+(k-row); after row+num_act beats -> WL0.
REQ-013 WL0: row cycles of xmem reads (CEN=0, WEN=1) at w_base..w_base+row-1; l0_wr SHALL assert one cycle after each read (1-cycle SRAM latency), so state exits one cycle after last read -> KLOAD.
REQ-014 KLOAD: row cycles with inst[0]=1 and l0_rd=1 -> KDRAIN.
REQ-015 KDRAIN: col idle cycles -> AL0, or DONE if num_act=0.
REQ-016 AL0: num_act xmem reads at a_base.. with delayed l0_wr as in WL0 -> EXEC.
REQ-017 EXEC: num_act cycles with inst[1]=1 and l0_rd=1 -> OUT.
REQ-018 OUT: each cycle ofifo_valid=1 SHALL assert ofifo_rd; the cycle after each ofifo_rd SHALL write pmem (CEN=0, WEN=0) at p_base+j, j incrementing; after num_act pmem writes -> DONE.
REQ-019 OUT with ofifo_valid=0 SHALL hold (no rd, no write); no timeout.
REQ-020 DONE: done=1 for one cycle -> IDLE; busy=1 in every state except IDLE.
REQ-021 Address arithmetic SHALL be 11-bit modulo 2048 (wrap past 2047 to 0).
REQ-022 in_ready SHALL be 0 outside XLOAD; in_valid there is ignored.
REQ-023 d_xmem SHALL equal in_data combinationally.

Reset
REQ-024 reset low SHALL asynchronously force IDLE, counters 0, inst=idle word with [33]=0, in_ready=0, busy=0, done=0, including mid-job; a pending delayed l0_wr or pmem write SHALL be cancelled.

Structure
REQ-025 SHALL place state encoding and inst bit-position constants in shared package core_pkg.
REQ-026 SHALL use one sub-module, ctrl_addr_cnt (loadable 11-bit wrapping address counter with count-done compare), instanced for xmem and pmem pointers.

Verification
REQ-027 row=8, num_act=4, w_base=0, a_base=16, p_base=100: 12 beats -> xmem writes at 0..7, 16..19; 8 l0_wr, 8 kernel-load cycles, 8 idle, 4 l0_wr, 4 execute cycles.
REQ-028 Same job, ofifo_valid held 1 -> 4 ofifo_rd, pmem writes at 100..103 each one cycle later, done pulse once, busy falls same cycle as done deasserts.
REQ-029 ofifo_valid toggling 1,0,0,1,1,1 -> ofifo_rd only on 1s; pmem addresses contiguous, no gaps.
REQ-030 num_act=0 -> 8 load beats only, no execute, no pmem write, done after KDRAIN.
REQ-031 a_base=2046, num_act=4 -> activation writes at 2046, 2047, 0, 1.
REQ-032 reset low during EXEC, then start -> inst equals idle word immediately, busy=0; new job runs from XLOAD correctly; start during busy ignored.
